// File: rtl/decode_stage.sv
// MIPS decode stage feeding registers_array: 1-cycle decode with a registered output and load-use scoreboard.
// Stalls fetch (in_ready low) when the output is held, a source awaits load writeback, or flush is asserted.
module decode_stage #(
  parameter logic [4:0] NONE_REG = 5'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rnum1,
  output logic [4:0]  rnum2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [4:0]  out_wnum,
  output logic        out_write,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_branch,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_num,
  input  logic        flush
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_LUI = 4'd8, OP_NOP = 4'd15;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  wnum;
    logic        write;
    logic [31:0] imm;
    logic        is_load;
    logic        is_store;
    logic        branch;
    logic        illegal;
  } dec_t;

  logic [5:0]  opc, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, zimm;
  dec_t        dec;
  logic        uses_rt;
  logic [31:0] pending, pending_nxt;
  logic [4:0]  held_rs, held_rt;
  logic        rs_wait, rt_wait, hazard, fire_in, fire_out;

  assign opc   = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign shamt = in_instr[10:6];
  assign funct = in_instr[5:0];
  assign simm  = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zimm  = {16'b0, in_instr[15:0]};

  always_comb begin
    dec     = '0;
    dec.op  = OP_NOP;
    uses_rt = 1'b0;
    case (opc)
      6'h00: begin
        uses_rt   = 1'b1;
        dec.wnum  = rd;
        dec.write = 1'b1;
        case (funct)
          6'h21: dec.op = OP_ADD;
          6'h23: dec.op = OP_SUB;
          6'h24: dec.op = OP_AND;
          6'h25: dec.op = OP_OR;
          6'h26: dec.op = OP_XOR;
          6'h2A: dec.op = OP_SLT;
          6'h00: begin dec.op = OP_SLL; dec.imm = {27'b0, shamt}; end
          6'h02: begin dec.op = OP_SRL; dec.imm = {27'b0, shamt}; end
          default: begin dec.illegal = 1'b1; dec.write = 1'b0; dec.wnum = '0; end
        endcase
      end
      6'h09: begin dec.op = OP_ADD; dec.imm = simm; dec.wnum = rt; dec.write = 1'b1; end
      6'h0A: begin dec.op = OP_SLT; dec.imm = simm; dec.wnum = rt; dec.write = 1'b1; end
      6'h0C: begin dec.op = OP_AND; dec.imm = zimm; dec.wnum = rt; dec.write = 1'b1; end
      6'h0D: begin dec.op = OP_OR;  dec.imm = zimm; dec.wnum = rt; dec.write = 1'b1; end
      6'h0E: begin dec.op = OP_XOR; dec.imm = zimm; dec.wnum = rt; dec.write = 1'b1; end
      6'h0F: begin dec.op = OP_LUI; dec.imm = {in_instr[15:0], 16'b0}; dec.wnum = rt; dec.write = 1'b1; end
      6'h23: begin
        dec.op = OP_ADD; dec.imm = simm; dec.wnum = rt; dec.write = 1'b1; dec.is_load = 1'b1;
      end
      6'h2B: begin dec.op = OP_ADD; dec.imm = simm; dec.is_store = 1'b1; uses_rt = 1'b1; end
      6'h04, 6'h05: begin
        dec.op = OP_SUB; dec.imm = {simm[29:0], 2'b00}; dec.branch = 1'b1; uses_rt = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.wnum == NONE_REG) dec.write = 1'b0;
  end

  // A writeback landing this cycle releases its register immediately.
  assign rs_wait  = (rs != NONE_REG) && pending[rs] && !(wb_valid && wb_num == rs);
  assign rt_wait  = uses_rt && (rt != NONE_REG) && pending[rt] && !(wb_valid && wb_num == rt);
  assign hazard   = rs_wait || rt_wait;
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  // Held sources are re-read every cycle so rdata stays aligned with the held instruction.
  assign rnum1 = fire_in ? rs : held_rs;
  assign rnum2 = fire_in ? rt : held_rt;

  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_num] = 1'b0;
    if (fire_out && !flush && out_is_load && out_wnum != NONE_REG) pending_nxt[out_wnum] = 1'b1;
    pending_nxt[NONE_REG] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= '0;
      held_rs      <= '0;
      held_rt      <= '0;
      out_valid    <= 1'b0;
      out_op       <= OP_NOP;
      out_wnum     <= '0;
      out_write    <= 1'b0;
      out_imm      <= '0;
      out_pc       <= '0;
      out_is_load  <= 1'b0;
      out_is_store <= 1'b0;
      out_branch   <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire_in) begin
        out_valid    <= 1'b1;
        held_rs      <= rs;
        held_rt      <= rt;
        out_op       <= dec.op;
        out_wnum     <= dec.wnum;
        out_write    <= dec.write;
        out_imm      <= dec.imm;
        out_pc       <= in_pc;
        out_is_load  <= dec.is_load;
        out_is_store <= dec.is_store;
        out_branch   <= dec.branch;
        out_illegal  <= dec.illegal;
      end else if (fire_out) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rnum1, rnum2;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [4:0]  out_wnum;
  logic        out_write;
  logic [31:0] out_imm, out_pc;
  logic        out_is_load, out_is_store, out_branch, out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_num;
  logic        flush;

  int tests_run = 0;
  int tests_failed = 0;

  decode_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rnum1(rnum1), .rnum2(rnum2),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_wnum(out_wnum),
    .out_write(out_write), .out_imm(out_imm), .out_pc(out_pc),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_branch(out_branch),
    .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_num(wb_num), .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drain a held instruction with no new input.
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  // Accept one instruction then inspect the decoded fields.
  task automatic decode_one(input string tag, input logic [31:0] instr, input logic [3:0] op,
                            input logic [4:0] wnum, input logic wr, input logic [31:0] imm);
    in_valid = 1'b1; in_instr = instr; out_ready = 1'b1;
    #1 check({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check({tag, "_op"}, out_op, op);
    check({tag, "_wnum"}, out_wnum, wnum);
    check({tag, "_write"}, out_write, wr);
    check({tag, "_imm"}, out_imm, imm);
    drain();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_num = '0; flush = 1'b0;
    #12;
    check("rst_vld", out_valid, 0);
    check("rst_op", out_op, 15);
    check("rst_write", out_write, 0);
    check("rst_imm", out_imm, 0);
    check("rst_pc", out_pc, 0);
    check("rst_flags", {out_is_load, out_is_store, out_branch, out_illegal}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // ADDIU $5,$3,-4
    in_valid = 1'b1; in_instr = 32'h2465FFFC; in_pc = 32'h100;
    #1;
    check("addiu_rdy", in_ready, 1);
    check("addiu_rnum1", rnum1, 3);
    tick();
    in_valid = 1'b0;
    #1;
    check("addiu_vld", out_valid, 1);
    check("addiu_op", out_op, 0);
    check("addiu_wnum", out_wnum, 5);
    check("addiu_write", out_write, 1);
    check("addiu_imm", out_imm, 32'hFFFFFFFC);
    check("addiu_pc", out_pc, 32'h100);

    // ADDU $1,$2,$3 replaces it, then held with out_ready low
    in_valid = 1'b1; in_instr = 32'h00430821; in_pc = 32'h104; out_ready = 1'b1;
    #1 check("addu_rdy", in_ready, 1);
    tick();
    out_ready = 1'b0; in_instr = 32'h2465FFFC; in_pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_rdy", in_ready, 0);
      check("hold_rnum1", rnum1, 2);
      check("hold_rnum2", rnum2, 3);
      check("hold_wnum", out_wnum, 1);
      check("hold_pc", out_pc, 32'h104);
      tick();
    end
    drain();

    // LW $4,8($2), drained so pending[4] is set, then ADDU $6,$4,$1 stalls
    decode_one("lw", 32'h8C440008, 4'd0, 5'd4, 1'b1, 32'h8);
    in_valid = 1'b1; in_instr = 32'h00813021; in_pc = 32'h200; out_ready = 1'b1;
    #1 check("lu_stall0", in_ready, 0);
    tick();
    wb_valid = 1'b1; wb_num = 5'd5;
    #1 check("lu_stall_wrongwb", in_ready, 0);
    tick();
    wb_num = 5'd4;
    #1 check("lu_wb_same_cycle", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("lu_vld", out_valid, 1);
    check("lu_wnum", out_wnum, 6);
    drain();

    // LW into $0 then a read of $0: no stall
    decode_one("lw0", 32'h8C400004, 4'd0, 5'd0, 1'b0, 32'h4);
    in_valid = 1'b1; in_instr = 32'h00003821;
    #1 check("r0_nostall", in_ready, 1);
    tick();
    drain();

    decode_one("sll", 32'h00031100, 4'd6, 5'd2, 1'b1, 32'h4);
    decode_one("lui", 32'h3C081234, 4'd8, 5'd8, 1'b1, 32'h12340000);
    decode_one("andi", 32'h30238000, 4'd2, 5'd3, 1'b1, 32'h00008000);
    decode_one("ill", 32'hFC000000, 4'd15, 5'd0, 1'b0, 32'h0);

    // Illegal flag needs its own look: re-accept and hold
    in_valid = 1'b1; in_instr = 32'hFC000000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check("ill_flag", out_illegal, 1);
    drain();

    // LW $9 sets pending[9]; BEQ $1,$2,+3 held then flushed
    decode_one("lw9", 32'h8C290000, 4'd0, 5'd9, 1'b1, 32'h0);
    decode_one("beq", 32'h10220003, 4'd1, 5'd0, 1'b0, 32'hC);
    in_valid = 1'b1; in_instr = 32'h10220003; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check("beq_branch", out_branch, 1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2465FFFC;
    #1 check("flush_rdy", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1 check("flush_vld", out_valid, 0);
    in_valid = 1'b1; in_instr = 32'h01205021;
    #1 check("flush_pending_kept", in_ready, 0);
    in_valid = 1'b0;

    // Hold ADDIU with pending[9] still set, then reset mid-stall
    in_valid = 1'b1; in_instr = 32'h2465FFFC;
    tick();
    in_instr = 32'h01205021;
    #1 check("pre_rst_vld", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("arst_vld", out_valid, 0);
    check("arst_op", out_op, 15);
    reset_n = 1'b1;
    #1 check("arst_pending_clr", in_ready, 1);

    in_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
